mw_pipe_reg_n: RTL and testbench

Parametrised memory/writeback pipeline register for the multi-issue datapath. It generalises the fixed two-lane (top/bottom) latch to LANES lanes. Each lane carries the ALU result (O), the store/load data (D), the instruction word and the overflow flag. Over the fixed latch it adds per-lane valid bits, a synchronous flush, per-lane kill (bubble insertion), a registered valid-lane count and a saturating stall-cycle counter for performance monitoring.

---
 rtl/mw_pipe_reg_n.sv | 118 +++++++++++
 tb/tb_mw_pipe_reg_n.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mw_pipe_reg_n.sv
// mw_pipe_reg_n: memory/writeback pipeline register for LANES issue lanes.
// Each lane latches the ALU result, D data, instruction word and overflow flag
// together with a valid bit. Adds flush, per-lane kill, a registered
// valid-lane count and a saturating stall-cycle counter.
module mw_pipe_reg_n #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int INSN_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic                      flush,
    input  logic                      clr_count,
    input  logic [LANES-1:0]          valid_in,
    input  logic [LANES-1:0]          kill_in,
    input  logic [LANES*DATA_W-1:0]   dataO_in,
    input  logic [LANES*DATA_W-1:0]   dataD_in,
    input  logic [LANES*INSN_W-1:0]   instruction_in,
    input  logic [LANES-1:0]          ovf_in,
    output logic [LANES-1:0]          valid_out,
    output logic [LANES*DATA_W-1:0]   dataO_out,
    output logic [LANES*DATA_W-1:0]   dataD_out,
    output logic [LANES*INSN_W-1:0]   instruction_out,
    output logic [LANES-1:0]          ovf_out,
    output logic [$clog2(LANES+1)-1:0] lane_count,
    output logic [CNT_W-1:0]          stall_count
);

    localparam int LCW = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [LANES-1:0]        validReg;
    logic [LANES-1:0]        validNext;
    logic [LANES*DATA_W-1:0] dataOReg;
    logic [LANES*DATA_W-1:0] dataDReg;
    logic [LANES*INSN_W-1:0] insnReg;
    logic [LANES-1:0]        ovfReg;
    logic [LCW-1:0]          laneCountReg;
    logic [LCW-1:0]          laneCountNext;
    logic [CNT_W-1:0]        stallCountReg;
    logic                    stallCond;

    // A lane captures only when advancing, not flushed, valid and not killed.
    logic [LANES-1:0] laneLoad;
    assign laneLoad = {LANES{we & ~flush}} & valid_in & ~kill_in;

    // Next valid vector mirrors the per-lane priority so lane_count can be
    // registered in the same edge as valid_out.
    always_comb begin
        validNext = validReg;
        if (reset || flush) begin
            validNext = '0;
        end else if (we) begin
            validNext = valid_in & ~kill_in;
        end
    end

    // Popcount of the next valid vector.
    always_comb begin
        laneCountNext = '0;
        for (int i = 0; i < LANES; i++) begin
            laneCountNext = laneCountNext + LCW'(validNext[i]);
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            // Per-lane payload: bubble on reset/flush/kill, capture on load, else hold.
            always_ff @(posedge clk) begin
                if (reset || flush || (we && !laneLoad[gi])) begin
                    validReg[gi]                   <= 1'b0;
                    dataOReg[gi*DATA_W +: DATA_W]  <= '0;
                    dataDReg[gi*DATA_W +: DATA_W]  <= '0;
                    insnReg[gi*INSN_W +: INSN_W]   <= '0;
                    ovfReg[gi]                     <= 1'b0;
                end else if (we) begin
                    validReg[gi]                   <= 1'b1;
                    dataOReg[gi*DATA_W +: DATA_W]  <= dataO_in[gi*DATA_W +: DATA_W];
                    dataDReg[gi*DATA_W +: DATA_W]  <= dataD_in[gi*DATA_W +: DATA_W];
                    insnReg[gi*INSN_W +: INSN_W]   <= instruction_in[gi*INSN_W +: INSN_W];
                    ovfReg[gi]                     <= ovf_in[gi];
                end
            end
        end
    endgenerate

    // Registered valid-lane count, tracks validReg edge for edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            laneCountReg <= '0;
        end else begin
            laneCountReg <= laneCountNext;
        end
    end

    // A stall only counts when valid work is actually being held.
    assign stallCond = ~we & ~flush & (|validReg);

    // Saturating stall counter; clear beats increment.
    always_ff @(posedge clk) begin
        if (reset || clr_count) begin
            stallCountReg <= '0;
        end else if (stallCond && (stallCountReg != CNT_MAX)) begin
            stallCountReg <= stallCountReg + 1'b1;
        end
    end

    assign valid_out       = validReg;
    assign dataO_out       = dataOReg;
    assign dataD_out       = dataDReg;
    assign instruction_out = insnReg;
    assign ovf_out         = ovfReg;
    assign lane_count      = laneCountReg;
    assign stall_count     = stallCountReg;

endmodule

// File: tb/tb_mw_pipe_reg_n.sv
// Directed self-checking bench for mw_pipe_reg_n: default (2 lanes),
// narrow stall counter (CNT_W=3) and a wide 4-lane/16-bit instance.
module tb_mw_pipe_reg_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    int errors = 0;
    int checks = 0;

    // ---------------- default instance (LANES=2) ----------------
    logic        aWe, aFlush, aClr;
    logic [1:0]  aValid, aKill, aOvf;
    logic [63:0] aO, aD, aIns;
    logic [1:0]  aValidOut, aOvfOut;
    logic [63:0] aOOut, aDOut, aInsOut;
    logic [1:0]  aLaneCnt;
    logic [15:0] aStall;

    mw_pipe_reg_n dutA (
        .clk(clk), .reset(reset), .we(aWe), .flush(aFlush), .clr_count(aClr),
        .valid_in(aValid), .kill_in(aKill), .dataO_in(aO), .dataD_in(aD),
        .instruction_in(aIns), .ovf_in(aOvf),
        .valid_out(aValidOut), .dataO_out(aOOut), .dataD_out(aDOut),
        .instruction_out(aInsOut), .ovf_out(aOvfOut),
        .lane_count(aLaneCnt), .stall_count(aStall)
    );

    // ---------------- saturation instance (CNT_W=3) ----------------
    logic        sWe, sFlush, sClr;
    logic [1:0]  sValid, sKill, sOvf;
    logic [63:0] sO, sD, sIns;
    logic [1:0]  sValidOut, sOvfOut;
    logic [63:0] sOOut, sDOut, sInsOut;
    logic [1:0]  sLaneCnt;
    logic [2:0]  sStall;

    mw_pipe_reg_n #(.CNT_W(3)) dutS (
        .clk(clk), .reset(reset), .we(sWe), .flush(sFlush), .clr_count(sClr),
        .valid_in(sValid), .kill_in(sKill), .dataO_in(sO), .dataD_in(sD),
        .instruction_in(sIns), .ovf_in(sOvf),
        .valid_out(sValidOut), .dataO_out(sOOut), .dataD_out(sDOut),
        .instruction_out(sInsOut), .ovf_out(sOvfOut),
        .lane_count(sLaneCnt), .stall_count(sStall)
    );

    // ---------------- wide instance (LANES=4, DATA_W=16) ----------------
    logic         wWe, wFlush, wClr;
    logic [3:0]   wValid, wKill, wOvf;
    logic [63:0]  wO, wD;
    logic [127:0] wIns;
    logic [3:0]   wValidOut, wOvfOut;
    logic [63:0]  wOOut, wDOut;
    logic [127:0] wInsOut;
    logic [2:0]   wLaneCnt;
    logic [15:0]  wStall;

    mw_pipe_reg_n #(.LANES(4), .DATA_W(16)) dutW (
        .clk(clk), .reset(reset), .we(wWe), .flush(wFlush), .clr_count(wClr),
        .valid_in(wValid), .kill_in(wKill), .dataO_in(wO), .dataD_in(wD),
        .instruction_in(wIns), .ovf_in(wOvf),
        .valid_out(wValidOut), .dataO_out(wOOut), .dataD_out(wDOut),
        .instruction_out(wInsOut), .ovf_out(wOvfOut),
        .lane_count(wLaneCnt), .stall_count(wStall)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s failed", tag);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with random inputs on every instance.
        reset = 1'b1;
        aWe = 1'b1; aFlush = 1'b0; aClr = 1'b0;
        aValid = 2'b11; aKill = 2'b00; aOvf = 2'b11;
        aO = {$urandom, $urandom}; aD = {$urandom, $urandom}; aIns = {$urandom, $urandom};
        sWe = 1'b1; sFlush = 1'b0; sClr = 1'b0; sValid = 2'b11; sKill = 2'b00; sOvf = 2'b11;
        sO = {$urandom, $urandom}; sD = {$urandom, $urandom}; sIns = {$urandom, $urandom};
        wWe = 1'b1; wFlush = 1'b0; wClr = 1'b0; wValid = 4'hF; wKill = 4'h0; wOvf = 4'hF;
        wO = {$urandom, $urandom}; wD = {$urandom, $urandom};
        wIns = {$urandom, $urandom, $urandom, $urandom};

        for (int r = 0; r < 2; r++) begin
            step();
            chk("rst_valid",  {126'd0, aValidOut}, 128'd0);
            chk("rst_dataO",  {64'd0, aOOut}, 128'd0);
            chk("rst_dataD",  {64'd0, aDOut}, 128'd0);
            chk("rst_insn",   {64'd0, aInsOut}, 128'd0);
            chk("rst_ovf",    {126'd0, aOvfOut}, 128'd0);
            chk("rst_lcnt",   {126'd0, aLaneCnt}, 128'd0);
            chk("rst_stall",  {112'd0, aStall}, 128'd0);
            chk("rst_s_valid",{126'd0, sValidOut}, 128'd0);
            chk("rst_w_valid",{124'd0, wValidOut}, 128'd0);
            chk("rst_w_insn", wInsOut, 128'd0);
        end

        reset = 1'b0;
        sWe = 1'b0; sValid = 2'b00; sOvf = 2'b00;
        wWe = 1'b0; wValid = 4'h0; wOvf = 4'h0;

        // Capture with kill on lane 1.
        aWe = 1'b1; aValid = 2'b11; aKill = 2'b10; aOvf = 2'b11;
        aO   = {32'hDEAD_BEEF, 32'h0000_0011};
        aD   = {32'hCAFE_F00D, 32'h0000_0022};
        aIns = {32'h1234_5678, 32'h2800_0005};
        step();
        chk("kill_valid", {126'd0, aValidOut}, 128'h1);
        chk("kill_dataO", {64'd0, aOOut}, 128'h0000_0000_0000_0011);
        chk("kill_dataD", {64'd0, aDOut}, 128'h0000_0000_0000_0022);
        chk("kill_insn",  {64'd0, aInsOut}, 128'h0000_0000_2800_0005);
        chk("kill_ovf",   {126'd0, aOvfOut}, 128'h1);
        chk("kill_lcnt",  {126'd0, aLaneCnt}, 128'd1);

        // Capture both lanes.
        aKill = 2'b00; aOvf = 2'b10;
        aO   = {32'h1111_2222, 32'h3333_4444};
        aD   = {32'h5555_6666, 32'h7777_8888};
        aIns = {32'h9999_AAAA, 32'hBBBB_CCCC};
        step();
        chk("cap_valid", {126'd0, aValidOut}, 128'h3);
        chk("cap_dataO", {64'd0, aOOut}, 128'h1111_2222_3333_4444);
        chk("cap_ovf",   {126'd0, aOvfOut}, 128'h2);
        chk("cap_lcnt",  {126'd0, aLaneCnt}, 128'd2);
        chk("cap_stall", {112'd0, aStall}, 128'd0);

        // Stall 5 cycles with changed inputs.
        aWe = 1'b0; aValid = 2'b01; aKill = 2'b11;
        aO = 64'hFFFF_FFFF_FFFF_FFFF; aIns = 64'h0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("stall_cnt",   {112'd0, aStall}, 128'(k));
            chk("stall_dataO", {64'd0, aOOut}, 128'h1111_2222_3333_4444);
            chk("stall_insn",  {64'd0, aInsOut}, 128'h9999_AAAA_BBBB_CCCC);
        end

        // Clear coincident with stall condition -> 0.
        aClr = 1'b1;
        step();
        chk("clr_stall", {112'd0, aStall}, 128'd0);
        chk("clr_valid", {126'd0, aValidOut}, 128'h3);
        aClr = 1'b0;
        step();
        chk("resume_stall", {112'd0, aStall}, 128'd1);

        // Reset mid-stall, then capture on first edge after release.
        reset = 1'b1;
        step();
        chk("mrst_valid", {126'd0, aValidOut}, 128'd0);
        chk("mrst_stall", {112'd0, aStall}, 128'd0);
        reset = 1'b0; aWe = 1'b1; aValid = 2'b11; aKill = 2'b00;
        aIns = {32'hAAAA_0001, 32'hBBBB_0002};
        step();
        chk("post_rst_insn", {64'd0, aInsOut}, 128'hAAAA_0001_BBBB_0002);
        chk("post_rst_lcnt", {126'd0, aLaneCnt}, 128'd2);

        // Flush wins over we=1 with valid data.
        aFlush = 1'b1; aIns = 64'h0123_4567_89AB_CDEF;
        step();
        chk("flush_valid", {126'd0, aValidOut}, 128'd0);
        chk("flush_insn",  {64'd0, aInsOut}, 128'd0);
        chk("flush_dataO", {64'd0, aOOut}, 128'd0);
        chk("flush_lcnt",  {126'd0, aLaneCnt}, 128'd0);
        aFlush = 1'b0; aWe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_stall", {112'd0, aStall}, 128'd0);
        end

        // Saturation on CNT_W=3.
        sWe = 1'b1; sValid = 2'b01; sKill = 2'b00; sIns = 64'h0000_0000_0000_0042;
        step();
        chk("sat_valid", {126'd0, sValidOut}, 128'h1);
        sWe = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("sat_cnt", {125'd0, sStall}, 128'((k > 7) ? 7 : k));
        end
        sClr = 1'b1;
        step();
        chk("sat_clr", {125'd0, sStall}, 128'd0);
        sClr = 1'b0;

        // Wide instance: per-lane slices with lane 2 invalid.
        wWe = 1'b1; wValid = 4'b1011; wKill = 4'b0000; wOvf = 4'b1111;
        wO   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        wD   = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
        wIns = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
        step();
        chk("w_valid", {124'd0, wValidOut}, 128'hB);
        chk("w_dataO", {64'd0, wOOut}, 128'hA003_0000_A001_A000);
        chk("w_dataD", {64'd0, wDOut}, 128'hB003_0000_B001_B000);
        chk("w_insn",  wInsOut, 128'hC000_0003_0000_0000_C000_0001_C000_0000);
        chk("w_ovf",   {124'd0, wOvfOut}, 128'hB);
        chk("w_lcnt",  {125'd0, wLaneCnt}, 128'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
